// File: rtl/vproc_vreg_wr_arbiter.sv
// Round-robin arbiter that maps up to PORTS_WR of REQ_N write requesters onto
// the vector register file write ports. Granted requests never share an address
// in the same cycle, which the XOR-banked register file depends on.

// One registered write port: loads the selected request, otherwise holds
// addr/data/be and deasserts we.
module vproc_vreg_wr_port #(
    parameter int AW     = 7,
    parameter int PORT_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [PORT_W-1:0]   data_i,
    input  logic [PORT_W/8-1:0] be_i,
    output logic [AW-1:0]       wr_addr_o,
    output logic [PORT_W-1:0]   wr_data_o,
    output logic [PORT_W/8-1:0] wr_be_o,
    output logic                wr_we_o
);

    // Capture the granted request; unused ports keep their last payload.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_we_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            wr_be_o   <= '0;
        end else begin
            wr_we_o <= load_i;
            if (load_i) begin
                wr_addr_o <= addr_i;
                wr_data_o <= data_i;
                wr_be_o   <= be_i;
            end
        end
    end

endmodule

module vproc_vreg_wr_arbiter #(
    parameter int VREG_W   = 128,
    parameter int PORT_W   = 32,
    parameter int REQ_N    = 4,
    parameter int PORTS_WR = 2,
    localparam int AW      = 5 + $clog2(VREG_W / PORT_W),
    localparam int BW      = PORT_W / 8,
    localparam int PTR_W   = (REQ_N > 1) ? $clog2(REQ_N) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [REQ_N-1:0]                   req_valid_i,
    output logic [REQ_N-1:0]                   req_ready_o,
    input  logic [REQ_N-1:0][AW-1:0]           req_addr_i,
    input  logic [REQ_N-1:0][PORT_W-1:0]       req_data_i,
    input  logic [REQ_N-1:0][BW-1:0]           req_be_i,
    output logic [PORTS_WR-1:0][AW-1:0]        wr_addr_o,
    output logic [PORTS_WR-1:0][PORT_W-1:0]    wr_data_o,
    output logic [PORTS_WR-1:0][BW-1:0]        wr_be_o,
    output logic [PORTS_WR-1:0]                wr_we_o,
    output logic [PTR_W-1:0]                   rr_ptr_o
);

    logic [PTR_W-1:0]                rr_ptr;
    logic [PTR_W-1:0]                ptr_nxt;
    logic [REQ_N-1:0]                grant;
    logic [PORTS_WR-1:0]             port_vld;
    logic [PORTS_WR-1:0][PTR_W-1:0]  port_sel;

    // Walk requesters from rr_ptr; the n-th grant lands on port n. A request
    // whose address matches an earlier grant this cycle simply waits.
    always_comb begin : p_grant
        int   n;
        int   r;
        logic hit;
        grant    = '0;
        port_vld = '0;
        port_sel = '0;
        ptr_nxt  = rr_ptr;
        n        = 0;
        for (int i = 0; i < REQ_N; i++) begin
            r   = (int'(rr_ptr) + i) % REQ_N;
            hit = 1'b0;
            for (int k = 0; k < PORTS_WR; k++)
                if (k < n && req_addr_i[port_sel[k]] == req_addr_i[r])
                    hit = 1'b1;
            if (!rst_i && req_valid_i[r] && n < PORTS_WR && !hit) begin
                grant[r] = 1'b1;
                for (int k = 0; k < PORTS_WR; k++)
                    if (k == n) begin
                        port_vld[k] = 1'b1;
                        port_sel[k] = PTR_W'(r);
                    end
                ptr_nxt = PTR_W'((r + 1) % REQ_N);
                n       = n + 1;
            end
        end
    end

    assign req_ready_o = grant;
    assign rr_ptr_o    = rr_ptr;

    // Priority head moves just past the last requester granted this cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rr_ptr <= '0;
        else       rr_ptr <= ptr_nxt;
    end

    for (genvar k = 0; k < PORTS_WR; k++) begin : g_port
        vproc_vreg_wr_port #(
            .AW     (AW),
            .PORT_W (PORT_W)
        ) u_port (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .load_i    (port_vld[k]),
            .addr_i    (req_addr_i[port_sel[k]]),
            .data_i    (req_data_i[port_sel[k]]),
            .be_i      (req_be_i[port_sel[k]]),
            .wr_addr_o (wr_addr_o[k]),
            .wr_data_o (wr_data_o[k]),
            .wr_be_o   (wr_be_o[k]),
            .wr_we_o   (wr_we_o[k])
        );
    end

    logic dup_wr;

    // Flag two enabled write ports hitting the same address.
    always_comb begin
        dup_wr = 1'b0;
        for (int i = 0; i < PORTS_WR; i++)
            for (int j = i + 1; j < PORTS_WR; j++)
                if (wr_we_o[i] && wr_we_o[j] && wr_addr_o[i] == wr_addr_o[j])
                    dup_wr = 1'b1;
    end

    a_no_dup_wr: assert property (@(posedge clk_i) disable iff (rst_i) !dup_wr);

endmodule
